// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 scan-code constants and parser state encoding
package ps2_pkg;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_EXT     = 2'd1;
    localparam state_t ST_BRK     = 2'd2;
    localparam state_t ST_EXT_BRK = 2'd3;
endpackage

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: turns E0/F0-prefixed PS/2 byte streams into make/break events
module ps2_scan_decoder
    import ps2_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_pressed,
    output logic       ev_valid,
    output logic       ev_make,
    output logic       ev_ext,
    output logic [7:0] ev_code
);
    state_t state_q, state_d;
    always_comb begin
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_make  = 1'b0;
        ev_ext   = 1'b0;
        ev_code  = key_data;
        if (key_pressed) begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = key_data == CODE_EXT ? ST_EXT : key_data == CODE_BRK ? ST_BRK : ST_IDLE;
                    ev_valid = key_data != CODE_EXT && key_data != CODE_BRK;
                    ev_make  = 1'b1;
                end
                ST_EXT: begin
                    state_d  = key_data == CODE_BRK ? ST_EXT_BRK : ST_IDLE;
                    ev_valid = key_data != CODE_BRK;
                    ev_make  = 1'b1;
                    ev_ext   = 1'b1;
                end
                ST_BRK: begin
                    state_d  = ST_IDLE;
                    ev_valid = 1'b1;
                end
                default: begin
                    state_d  = ST_IDLE;
                    ev_valid = 1'b1;
                    ev_ext   = 1'b1;
                end
            endcase
        end
    end
    always_ff @(posedge clock)
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
endmodule

// File: rtl/ps2_sprite_mover.sv
// ps2_sprite_mover: moves a sprite position with PS/2 arrow keys, saturating at screen bounds
module ps2_sprite_mover
    import ps2_pkg::*;
#(
    parameter int         X_WIDTH   = 10,
    parameter int         Y_WIDTH   = 9,
    parameter int         X_MAX     = 639,
    parameter int         Y_MAX     = 479,
    parameter int         X_INIT    = 320,
    parameter int         Y_INIT    = 240,
    parameter int         STEP      = 4,
    parameter int         MODE      = 1,
    parameter logic [7:0] KEY_UP    = CODE_UP,
    parameter logic [7:0] KEY_DOWN  = CODE_DOWN,
    parameter logic [7:0] KEY_LEFT  = CODE_LEFT,
    parameter logic [7:0] KEY_RIGHT = CODE_RIGHT,
    parameter int         KEY_EXT   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         ps2_key_data,
    input  logic               ps2_key_pressed,
    input  logic               frame_tick,
    output logic [X_WIDTH-1:0] pos_x,
    output logic [Y_WIDTH-1:0] pos_y,
    output logic [3:0]         held,
    output logic               moved
);
    localparam logic [X_WIDTH:0] X_STEP = (X_WIDTH+1)'(STEP);
    localparam logic [Y_WIDTH:0] Y_STEP = (Y_WIDTH+1)'(STEP);
    localparam logic [X_WIDTH:0] X_LIM  = (X_WIDTH+1)'(X_MAX);
    localparam logic [Y_WIDTH:0] Y_LIM  = (Y_WIDTH+1)'(Y_MAX);
    logic               ev_valid, ev_make, ev_ext;
    logic [7:0]         ev_code;
    logic [3:0]         hit, step_dir, held_q, held_d;
    logic               go_up, go_down, go_left, go_right, moved_q, moved_d;
    logic [X_WIDTH-1:0] pos_x_q, pos_x_d;
    logic [Y_WIDTH-1:0] pos_y_q, pos_y_d;
    logic [X_WIDTH:0]   x_ext, x_sum, x_dec, x_inc;
    logic [Y_WIDTH:0]   y_ext, y_sum, y_dec, y_inc;
    ps2_scan_decoder u_dec (
        .clock      (clock),
        .reset      (reset),
        .key_data   (ps2_key_data),
        .key_pressed(ps2_key_pressed),
        .ev_valid   (ev_valid),
        .ev_make    (ev_make),
        .ev_ext     (ev_ext),
        .ev_code    (ev_code)
    );
    always_comb begin
        hit      = {4{ev_valid && ev_ext == (KEY_EXT != 0)}} &
                   {ev_code == KEY_UP, ev_code == KEY_DOWN, ev_code == KEY_LEFT, ev_code == KEY_RIGHT};
        held_d   = ev_make ? held_q | hit : held_q & ~hit;
        // MODE 0 steps on fresh makes only; MODE 1 uses the held keys as they stood at the tick
        step_dir = MODE == 0 ? (ev_make ? hit & ~held_q : 4'b0) : (frame_tick ? held_q : 4'b0);
        go_up    = step_dir[3] & ~step_dir[2];
        go_down  = step_dir[2] & ~step_dir[3];
        go_left  = step_dir[1] & ~step_dir[0];
        go_right = step_dir[0] & ~step_dir[1];
        x_ext    = {1'b0, pos_x_q};
        y_ext    = {1'b0, pos_y_q};
        x_sum    = x_ext + X_STEP;
        y_sum    = y_ext + Y_STEP;
        x_dec    = x_ext < X_STEP ? '0 : x_ext - X_STEP;
        y_dec    = y_ext < Y_STEP ? '0 : y_ext - Y_STEP;
        x_inc    = x_sum > X_LIM ? X_LIM : x_sum;
        y_inc    = y_sum > Y_LIM ? Y_LIM : y_sum;
        pos_x_d  = go_left ? x_dec[X_WIDTH-1:0] : go_right ? x_inc[X_WIDTH-1:0] : pos_x_q;
        pos_y_d  = go_up ? y_dec[Y_WIDTH-1:0] : go_down ? y_inc[Y_WIDTH-1:0] : pos_y_q;
        moved_d  = pos_x_d != pos_x_q || pos_y_d != pos_y_q;
    end
    always_ff @(posedge clock)
        if (reset) begin
            held_q  <= 4'b0;
            pos_x_q <= X_WIDTH'(X_INIT);
            pos_y_q <= Y_WIDTH'(Y_INIT);
            moved_q <= 1'b0;
        end else begin
            held_q  <= held_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            moved_q <= moved_d;
        end
    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;
    assign held  = held_q;
    assign moved = moved_q;
endmodule

// File: tb/tb_ps2_sprite_mover.sv
// tb_ps2_sprite_mover: scoreboard bench over four differently parameterised movers
module tb_ps2_sprite_mover;
    typedef struct {
        int         id;
        int         x;
        int         y;
        logic [3:0] h;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       snap_req = 1'b0;
    logic [7:0] kd[4];
    logic       kp[4];
    logic       ft[4];
    logic [9:0] px[4];
    logic [8:0] py[4];
    logic [3:0] hd[4];
    logic       mv[4];
    exp_t       mq[$];
    exp_t       sq[$];
    int         n_chk = 0;
    int         n_fail = 0;
    always #5 clk = ~clk;
    ps2_sprite_mover #(.MODE(1)) u0 (
        .clock(clk), .reset(rst), .ps2_key_data(kd[0]), .ps2_key_pressed(kp[0]),
        .frame_tick(ft[0]), .pos_x(px[0]), .pos_y(py[0]), .held(hd[0]), .moved(mv[0]));
    ps2_sprite_mover #(.MODE(0)) u1 (
        .clock(clk), .reset(rst), .ps2_key_data(kd[1]), .ps2_key_pressed(kp[1]),
        .frame_tick(ft[1]), .pos_x(px[1]), .pos_y(py[1]), .held(hd[1]), .moved(mv[1]));
    ps2_sprite_mover #(.MODE(1), .X_INIT(2)) u2 (
        .clock(clk), .reset(rst), .ps2_key_data(kd[2]), .ps2_key_pressed(kp[2]),
        .frame_tick(ft[2]), .pos_x(px[2]), .pos_y(py[2]), .held(hd[2]), .moved(mv[2]));
    ps2_sprite_mover #(.MODE(1), .X_INIT(637)) u3 (
        .clock(clk), .reset(rst), .ps2_key_data(kd[3]), .ps2_key_pressed(kp[3]),
        .frame_tick(ft[3]), .pos_x(px[3]), .pos_y(py[3]), .held(hd[3]), .moved(mv[3]));
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++)
            if (mv[i] === 1'b1 && !rst) begin
                n_chk++;
                if (mq.size() == 0) begin
                    n_fail++;
                    $display("FAIL moved_u%0d: unexpected pulse at (%0d,%0d), required no pulse", i, px[i], py[i]);
                end else begin
                    e = mq.pop_front();
                    if (e.id != i || px[i] !== 10'(e.x) || py[i] !== 9'(e.y)) begin
                        n_fail++;
                        $display("FAIL moved_u%0d: got u%0d (%0d,%0d), required u%0d (%0d,%0d)",
                                 i, i, px[i], py[i], e.id, e.x, e.y);
                    end
                end
            end
        if (snap_req) begin
            n_chk++;
            if (sq.size() == 0) begin
                n_fail++;
                $display("FAIL snap: no expected entry queued");
            end else begin
                e = sq.pop_front();
                if (px[e.id] !== 10'(e.x) || py[e.id] !== 9'(e.y) || hd[e.id] !== e.h || mv[e.id] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL snap_u%0d: got pos (%0d,%0d) held %b moved %b, required (%0d,%0d) held %b moved 0",
                             e.id, px[e.id], py[e.id], hd[e.id], mv[e.id], e.x, e.y, e.h);
                end
            end
        end
    end
    task automatic send(input int i, input logic [7:0] b);
        @(posedge clk); #1;
        kd[i] = b; kp[i] = 1'b1;
        @(posedge clk); #1;
        kp[i] = 1'b0;
    endtask
    task automatic tick(input int i);
        @(posedge clk); #1;
        ft[i] = 1'b1;
        @(posedge clk); #1;
        ft[i] = 1'b0;
    endtask
    task automatic send_tick(input int i, input logic [7:0] b);
        @(posedge clk); #1;
        kd[i] = b; kp[i] = 1'b1; ft[i] = 1'b1;
        @(posedge clk); #1;
        kp[i] = 1'b0; ft[i] = 1'b0;
    endtask
    task automatic expect_move(input int i, input int x, input int y);
        mq.push_back('{id: i, x: x, y: y, h: 4'b0});
    endtask
    task automatic snap(input int i, input int x, input int y, input logic [3:0] h);
        sq.push_back('{id: i, x: x, y: y, h: h});
        @(posedge clk); #1;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 4; i++) begin
            kd[i] = 8'h00; kp[i] = 1'b0; ft[i] = 1'b0;
        end
        do_reset();
        repeat (10) @(posedge clk);
        snap(0, 320, 240, 4'b0000);
        snap(1, 320, 240, 4'b0000);
        snap(2, 2, 240, 4'b0000);
        snap(3, 637, 240, 4'b0000);
        send(0, 8'hE0); send(0, 8'h74);
        snap(0, 320, 240, 4'b0001);
        expect_move(0, 324, 240); expect_move(0, 328, 240); expect_move(0, 332, 240);
        tick(0); tick(0); tick(0);
        snap(0, 332, 240, 4'b0001);
        send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h74);
        tick(0);
        snap(0, 332, 240, 4'b0000);
        send(0, 8'hE0); send_tick(0, 8'h75);
        snap(0, 332, 240, 4'b1000);
        expect_move(0, 332, 236);
        tick(0);
        send(0, 8'hE0); send(0, 8'h72);
        tick(0);
        snap(0, 332, 236, 4'b1100);
        send(0, 8'h75);
        send(0, 8'hAA); send(0, 8'hFA); send(0, 8'hE1); send(0, 8'hFE);
        snap(0, 332, 236, 4'b1100);
        send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h72);
        send(0, 8'hE0); send(0, 8'h6B);
        expect_move(0, 328, 232);
        tick(0);
        snap(0, 328, 232, 4'b1010);
        expect_move(1, 320, 236);
        repeat (3) begin
            send(1, 8'hE0); send(1, 8'h75);
        end
        tick(1);
        snap(1, 320, 236, 4'b1000);
        send(1, 8'hE0); send(1, 8'hF0); send(1, 8'h75);
        expect_move(1, 320, 232);
        send(1, 8'hE0); send(1, 8'h75);
        snap(1, 320, 232, 4'b1000);
        send(2, 8'hE0); send(2, 8'h6B);
        expect_move(2, 0, 240);
        tick(2); tick(2);
        snap(2, 0, 240, 4'b0010);
        send(3, 8'hE0); send(3, 8'h74);
        expect_move(3, 639, 240);
        tick(3); tick(3);
        snap(3, 639, 240, 4'b0001);
        send(0, 8'hE0); send(0, 8'hF0);
        do_reset();
        send(0, 8'hE0); send(0, 8'h74);
        snap(0, 320, 240, 4'b0001);
        snap(2, 2, 240, 4'b0000);
        repeat (3) @(posedge clk);
        n_chk++;
        if (mq.size() != 0) begin
            n_fail++;
            $display("FAIL move_queue: %0d pulses never seen, required 0", mq.size());
        end
        n_chk++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL snap_queue: %0d snapshots unchecked, required 0", sq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_sprite_mover.md
PS2_SPRITE_MOVER -- requirements
Module: ps2_sprite_mover

Interface
REQ-001 SHALL have parameter X_WIDTH, default 10: pos_x width.
REQ-002 SHALL have parameter Y_WIDTH, default 9: pos_y width.
REQ-003 SHALL have parameters X_MAX 639 and Y_MAX 479: inclusive upper position bounds; the lower bound is 0.
REQ-004 SHALL have parameters X_INIT 320 and Y_INIT 240: reset position.
REQ-005 SHALL have parameter STEP, default 4: pixels per move; 1..X_MAX.
REQ-006 SHALL have parameter MODE, default 1: 0 = one step per key make, 1 = continuous step per frame_tick while the key is held.
REQ-007 SHALL have parameters KEY_UP 8'h75, KEY_DOWN 8'h72, KEY_LEFT 8'h6B, KEY_RIGHT 8'h74, and KEY_EXT 1 (1 = codes require the E0 prefix).
REQ-008 SHALL have port clock, input, 1 bit: the single clock. All logic is synchronous to it.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port ps2_key_data, input, 8 bits: received PS/2 byte.
REQ-011 SHALL have port ps2_key_pressed, input, 1 bit: one-cycle strobe; ps2_key_data is valid in that cycle.
REQ-012 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-013 SHALL have port pos_x, output, X_WIDTH bits: sprite X.
REQ-014 SHALL have port pos_y, output, Y_WIDTH bits: sprite Y.
REQ-015 SHALL have port held, output, 4 bits {up,down,left,right}: currently held keys.
REQ-016 SHALL have port moved, output, 1 bit: one-cycle pulse when the position changed.

Function
REQ-017 Scan-code parser FSM SHALL have states IDLE, EXT, BRK, EXT_BRK, and SHALL advance only on ps2_key_pressed.
- IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make event with ext=0, stay in IDLE.
- EXT: F0 -> EXT_BRK; any other byte -> make event with ext=1, go to IDLE.
- BRK: any byte -> break event with ext=0, go to IDLE.
- EXT_BRK: any byte -> break event with ext=1, go to IDLE.
REQ-018 An event SHALL match a direction only when the code equals KEY_x and ext equals KEY_EXT; non-matching events SHALL be ignored.
REQ-019 held bit SHALL set on a matching make and clear on a matching break, registered in the cycle after the strobe of the final byte.
REQ-020 MODE 0: a matching make with its held bit already 1 (typematic repeat) SHALL NOT move; otherwise one STEP SHALL be applied in that direction, with the position visible the cycle after the strobe.
REQ-021 MODE 1: on frame_tick, each axis SHALL move one STEP per held direction, using held as sampled in the tick cycle; the position updates the next cycle; frame_tick SHALL be ignored in MODE 0.
REQ-022 Up and down held together SHALL give no Y change; left and right held together SHALL give no X change; diagonals SHALL move both axes in the same update.
REQ-023 Up SHALL decrement Y, down increment Y, left decrement X, right increment X.
REQ-024 Arithmetic SHALL use width+1 bits and saturate.
- Decrement: pos < STEP -> 0.
- Increment: pos + STEP > MAX -> MAX.
- No wrap-around is permitted.
REQ-025 moved SHALL pulse exactly in the cycle the position register changes; a clamped no-change SHALL NOT pulse it.
REQ-026 A strobe coincident with frame_tick: the tick SHALL use the pre-update held value, and the event SHALL be applied normally.
REQ-027 Bytes AA, FA, E1 and FE in IDLE SHALL be ignored as ordinary non-matching makes.

Reset
REQ-028 Reset SHALL set: FSM = IDLE, held = 0, pos_x = X_INIT, pos_y = Y_INIT, moved = 0.
REQ-029 Reset mid-sequence (e.g. after E0 F0) SHALL discard the partial code; the next byte is parsed from IDLE.

Structure
REQ-030 Shared package ps2_pkg SHALL hold the scan-code constants (E0, F0, arrow codes) and the parser state typedef.
REQ-031 The parser SHALL be sub-module ps2_scan_decoder, with outputs event strobe, make/break, ext and code; position logic SHALL stay in the parent.

Verification
REQ-032 Reset, then idle 10 cycles -> pos (320,240), held 0, moved 0.
REQ-033 MODE 1: send E0 74, then 3 frame_ticks -> pos_x 332, moved pulses 3 times; send E0 F0 74, then a tick -> pos_x unchanged, held 0.
REQ-034 MODE 1, pos_x 2: hold left, 2 ticks -> pos_x 0, moved pulses once; hold right from 637 -> 639.
REQ-035 MODE 0: send E0 75 three times (repeat) -> pos_y 236 only; send break then E0 75 -> pos_y 232.
REQ-036 Hold up and down together, plus a tick -> pos_y unchanged; send 75 without E0 -> held unchanged.
REQ-037 Send E0 F0, then reset, then E0 74 -> held right = 1 (the partial break is discarded).
